// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin sharing of one multicycle hasher among NUM_REQ requesters; `HASH_ARBITER_STATS_EN adds done_count
module hash_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*64-1:0] req_data,
  input  logic [NUM_REQ*4-1:0]  req_len,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_hash,
  output logic                  busy,
  output logic [63:0]           hash_data,
  output logic [3:0]            hash_len,
  input  logic [31:0]           hash_in
`ifdef HASH_ARBITER_STATS_EN
  ,
  output logic [15:0]           done_count
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state;
  logic [IW-1:0] ptr, owner, sel;
  logic [3:0] cnt, sel_len;
  logic hit, hs;
  always_comb begin
    sel = ptr;
    hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sel = req[(int'(ptr) + i) % NUM_REQ] ? IW'((int'(ptr) + i) % NUM_REQ) : sel;
      hit = hit | req[(int'(ptr) + i) % NUM_REQ];
    end
    sel_len = req_len[4*int'(sel) +: 4] > 4'd8 ? 4'd8 : req_len[4*int'(sel) +: 4];
  end
  assign grant = (state == S_IDLE && hit && !reset) ? NUM_REQ'(1) << sel : '0;
  assign rsp_valid = state == S_RESP ? NUM_REQ'(1) << owner : '0;
  assign busy = state != S_IDLE;
  assign hs = state == S_RESP && rsp_ready[owner];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      hash_data <= '0;
      hash_len <= '0;
      rsp_hash <= '0;
    end else begin
      case (state)
        S_IDLE: if (hit) begin
          hash_data <= req_data[64*int'(sel) +: 64];
          hash_len <= sel_len;
          owner <= sel;
          ptr <= IW'((int'(sel) + 1) % NUM_REQ);
          cnt <= 4'(WAIT_CYCLES);
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rsp_hash <= hash_in;
            state <= S_RESP;
          end
        end
        S_RESP: if (hs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef HASH_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) done_count <= '0;
    else if (hs) done_count <= done_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter: directed vector table plus hand-written multicycle sequences for hash_arbiter
module tb_hash_arbiter;
  localparam int W = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = 4'b1111;
  logic [255:0] req_data = '0;
  logic [15:0] req_len = '0;
  logic [3:0] grant, rsp_valid;
  logic [3:0] rsp_ready = 4'b1111;
  logic [31:0] rsp_hash, hash_in;
  logic busy;
  logic [63:0] hash_data;
  logic [3:0] hash_len;
`ifdef HASH_ARBITER_STATS_EN
  logic [15:0] done_count;
`endif
  int vectors = 0;
  int fails = 0;
  typedef struct {
    logic [3:0] req;
    logic [63:0] data;
    logic [3:0] len;
    logic [3:0] gnt;
    logic [3:0] hlen;
    logic [31:0] hash;
  } vec_t;
  vec_t vt[5];
  always #5 clk = ~clk;
  assign hash_in = hash_data[63:32] ^ hash_data[31:0] ^ {hash_len, 28'h0};
  hash_arbiter #(.NUM_REQ(4), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_len(req_len),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hash(rsp_hash),
    .busy(busy), .hash_data(hash_data), .hash_len(hash_len), .hash_in(hash_in)
`ifdef HASH_ARBITER_STATS_EN
    , .done_count(done_count)
`endif
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask
  initial begin
    int n, t;
    int gc[5];
    logic [3:0] gq[5];
    vt[0] = '{4'b0100, 64'h0123_4567_89AB_CDEF, 4'd8, 4'b0100, 4'd8, 32'h0888_8888};
    vt[1] = '{4'b1111, 64'hFFFF_0000_0000_FFFF, 4'hF, 4'b1000, 4'd8, 32'h7FFF_FFFF};
    vt[2] = '{4'b0110, 64'h0000_0001_0000_0002, 4'h0, 4'b0010, 4'd0, 32'h0000_0003};
    vt[3] = '{4'b0011, 64'hAAAA_AAAA_5555_5555, 4'h9, 4'b0001, 4'd8, 32'h7FFF_FFFF};
    vt[4] = '{4'b1000, 64'h1234_5678_1234_5678, 4'h3, 4'b1000, 4'd3, 32'h3000_0000};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_hash_data", hash_data, 64'd0);
    end
    chk("rst_hash_len", 64'(hash_len), 64'd0);
    chk("rst_rsp_hash", 64'(rsp_hash), 64'd0);
    reset = 1'b0;
    req = '0;
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        req_data[64*i +: 64] = vt[v].gnt[i] ? vt[v].data : 64'hDEAD_BEEF_0000_0000 | 64'(i);
        req_len[4*i +: 4] = vt[v].gnt[i] ? vt[v].len : 4'd5;
      end
      req = vt[v].req;
      #1 chk("vec_grant", 64'(grant), 64'(vt[v].gnt));
      @(negedge clk);
      req = '0;
      chk("vec_hash_data", hash_data, vt[v].data);
      chk("vec_hash_len", 64'(hash_len), 64'(vt[v].hlen));
      repeat (W) @(negedge clk);
      chk("vec_rsp_valid", 64'(rsp_valid), 64'(vt[v].gnt));
      chk("vec_rsp_hash", 64'(rsp_hash), 64'(vt[v].hash));
    end
    @(negedge clk);
    req = 4'b1111;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      #1;
      if (grant != 0) begin
        gq[n] = grant;
        gc[n] = c;
        n++;
      end
      if (n < 5) @(negedge clk);
    end
    chk("rr_count", 64'(n), 64'd5);
    for (int k = 0; k < n; k++) begin
      chk("rr_order", 64'(gq[k]), 64'(4'b0001 << (k % 4)));
      if (k > 0) chk("rr_spacing", 64'(gc[k] - gc[k-1]), 64'd4);
    end
    @(negedge clk);
    req = '0;
    wait_idle();
    req_data[64 +: 64] = 64'h0000_0000_0000_00FF;
    req_len[4 +: 4] = 4'd1;
    req = 4'b0010;
    rsp_ready = 4'b0000;
    #1 chk("bp_grant", 64'(grant), 64'b0010);
    @(negedge clk);
    req = 4'b1111;
    rsp_ready = 4'b1101;
    t = 0;
    while (rsp_valid == 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int c = 0; c < 10; c++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
      chk("bp_rsp_hash", 64'(rsp_hash), 64'h1000_00FF);
      chk("bp_no_grant", 64'(grant), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    #1 chk("bp_next_grant", 64'(grant), 64'b0100);
    chk("bp_rsp_dropped", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    req = '0;
    rsp_ready = 4'b1111;
    wait_idle();
    req = 4'b1000;
    #1 chk("mid_grant", 64'(grant), 64'b1000);
    @(negedge clk);
    req = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < W + 3; c++) begin
      chk("mid_no_rsp", 64'(rsp_valid), 64'd0);
      chk("mid_not_busy", 64'(busy), 64'd0);
      @(negedge clk);
    end
`ifdef HASH_ARBITER_STATS_EN
    chk("stats_reset", 64'(done_count), 64'd0);
`endif
    req = 4'b1111;
    #1 chk("mid_ptr_zero", 64'(grant), 64'b0001);
    @(negedge clk);
    req = '0;
    wait_idle();
    for (int j = 0; j < 2; j++) begin
      req = 4'b0100;
      #1 chk("stats_grant", 64'(grant), 64'b0100);
      @(negedge clk);
      req = '0;
      wait_idle();
    end
`ifdef HASH_ARBITER_STATS_EN
    chk("stats_count", 64'(done_count), 64'd3);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
